// File: rtl/gnss_int_dump_acc.sv
// Multi-channel integrate-and-dump accumulator for tracking correlators.
// Sums signed I/Q products per channel and dumps closing sums on a code-epoch strobe.
`timescale 1ns/1ps
module gnss_int_dump_acc #(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 3,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 15,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic                    sample_valid,
  input  logic [NUM_CH*IN_W-1:0]  i_in,
  input  logic [NUM_CH*IN_W-1:0]  q_in,
  input  logic                    dump,
  input  logic                    acc_ready,
  output logic [NUM_CH*ACC_W-1:0] i_acc_out,
  output logic [NUM_CH*ACC_W-1:0] q_acc_out,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic [NUM_CH-1:0]       ovf,
  output logic                    acc_valid,
  output logic                    overrun
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Returns {overflow, new_acc}; the sum is formed one bit wider so overflow is exact.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [IN_W-1:0]  smp);
    logic [ACC_W:0] sum;
    logic           ov;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){smp[IN_W-1]}}, smp};
    ov  = sum[ACC_W] ^ sum[ACC_W-1];
    if (ov && SAT_EN) begin
      if (sum[ACC_W]) return {1'b1, ACC_MIN};
      else            return {1'b1, ACC_MAX};
    end else begin
      return {ov, sum[ACC_W-1:0]};
    end
  endfunction

  logic [NUM_CH-1:0][ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [NUM_CH-1:0][ACC_W-1:0] close_i_s, close_q_s;
  logic [NUM_CH-1:0][ACC_W-1:0] iout_q, iout_d, qout_q, qout_d;
  logic [NUM_CH-1:0]            ovf_q, ovf_d, close_ovf_s, ovf_out_q, ovf_out_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d, close_cnt_s, cnt_out_q, cnt_out_d;
  logic                         valid_q, valid_d, overrun_q, overrun_d;

  // Epoch totals including this cycle's sample; these are what a dump publishes.
  always_comb begin : close_calc
    logic [ACC_W:0] res_i;
    logic [ACC_W:0] res_q;
    res_i       = {(ACC_W+1){1'b0}};
    res_q       = {(ACC_W+1){1'b0}};
    close_i_s   = acc_i_q;
    close_q_s   = acc_q_q;
    close_ovf_s = ovf_q;
    close_cnt_s = cnt_q;
    if (sample_valid) begin
      for (int k = 0; k < NUM_CH; k++) begin
        res_i          = sat_add(acc_i_q[k], i_in[k*IN_W +: IN_W]);
        res_q          = sat_add(acc_q_q[k], q_in[k*IN_W +: IN_W]);
        close_i_s[k]   = res_i[ACC_W-1:0];
        close_q_s[k]   = res_q[ACC_W-1:0];
        close_ovf_s[k] = ovf_q[k] | res_i[ACC_W] | res_q[ACC_W];
      end
      if (cnt_q != CNT_MAX) begin
        close_cnt_s = cnt_q + CNT_W'(1);
      end else begin
        close_cnt_s = cnt_q;
      end
    end else begin
      close_cnt_s = cnt_q;
    end
  end

  // Accumulator restart on dump or disable, and output/handshake next state.
  always_comb begin
    acc_i_d   = close_i_s;
    acc_q_d   = close_q_s;
    ovf_d     = close_ovf_s;
    cnt_d     = close_cnt_s;
    iout_d    = iout_q;
    qout_d    = qout_q;
    ovf_out_d = ovf_out_q;
    cnt_out_d = cnt_out_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (!en || dump) begin
      acc_i_d = {(NUM_CH*ACC_W){1'b0}};
      acc_q_d = {(NUM_CH*ACC_W){1'b0}};
      ovf_d   = {NUM_CH{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      acc_i_d = close_i_s;
      acc_q_d = close_q_s;
    end
    if (en && dump) begin
      iout_d    = close_i_s;
      qout_d    = close_q_s;
      ovf_out_d = close_ovf_s;
      cnt_out_d = close_cnt_s;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~acc_ready;
    end else if (valid_q && acc_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_i_q   <= {(NUM_CH*ACC_W){1'b0}};
      acc_q_q   <= {(NUM_CH*ACC_W){1'b0}};
      ovf_q     <= {NUM_CH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      iout_q    <= {(NUM_CH*ACC_W){1'b0}};
      qout_q    <= {(NUM_CH*ACC_W){1'b0}};
      ovf_out_q <= {NUM_CH{1'b0}};
      cnt_out_q <= {CNT_W{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      iout_q    <= iout_d;
      qout_q    <= qout_d;
      ovf_out_q <= ovf_out_d;
      cnt_out_q <= cnt_out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign i_acc_out  = iout_q;
  assign q_acc_out  = qout_q;
  assign sample_cnt = cnt_out_q;
  assign ovf        = ovf_out_q;
  assign acc_valid  = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/gnss_int_dump_acc.md
Name: gnss_int_dump_acc

Overview:
Parametrised multi-channel integrate-and-dump accumulator for the tracking correlators; successor to the fixed ACC_W/acc_t accumulator type. Sums per-channel signed I/Q correlator products (e.g. Early/Prompt/Late) each valid sample and dumps on a code-epoch strobe. Adds configurable channel count, width, saturate/wrap mode, per-epoch sample count, overflow flags and an output valid/ready handshake with overrun detection. Sits between the code/carrier wipe-off multipliers and the tracking-loop discriminator logic.

Parameters:
NUM_CH, 3, number of correlator channels (E/P/L)
IN_W, 3, signed width of each per-channel I or Q input product
ACC_W, 16, signed accumulator/output width (default equals package ACC_W)
CNT_W, 15, sample-counter width (19200 samples/ms at SAMPLE_RATE fits)
SAT_EN, 1, 1 = saturate on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
en  in  1  channel enable; low clears accumulators and suppresses dumps
sample_valid  in  1  i_in/q_in valid this cycle
i_in  in  NUM_CH*IN_W  packed signed I products, channel 0 in LSBs
q_in  in  NUM_CH*IN_W  packed signed Q products, channel 0 in LSBs
dump  in  1  epoch strobe, single-cycle pulse
acc_ready  in  1  consumer accepts dumped result
i_acc_out  out  NUM_CH*ACC_W  packed signed dumped I sums
q_acc_out  out  NUM_CH*ACC_W  packed signed dumped Q sums
sample_cnt  out  CNT_W  number of valid samples in dumped epoch
ovf  out  NUM_CH  per-channel overflow (I or Q) during dumped epoch
acc_valid  out  1  dumped result pending
overrun  out  1  one-cycle pulse: dump overwrote an unaccepted result

Behaviour:
- Reset (nrst low, async): all internal accumulators, counter, overflow bits, i_acc_out, q_acc_out, sample_cnt, ovf = 0; acc_valid = 0; overrun = 0.
- Accumulate: each cycle en && sample_valid, acc_i[k] += sext(i_k), acc_q[k] += sext(q_k) for all k; cnt += 1 (saturates at 2^CNT_W-1, no wrap).
- Overflow: computed on ACC_W+1-bit sum. If out of [-2^(ACC_W-1), 2^(ACC_W-1)-1]: SAT_EN=1 clamp to nearest bound; SAT_EN=0 keep low ACC_W bits. Either mode sets internal ovf bit for that channel (sticky until dump).
- Dump (en && dump), cycle n: closing sums include the sample of cycle n if sample_valid. At n+1: outputs = closing sums, sample_cnt = closing count, ovf = closing flags, acc_valid = 1. Accumulators, counter, internal ovf restart at 0 at n+1 (next sample accumulates onto 0). Latency dump->acc_valid: 1 cycle.
- Handshake: acc_valid && acc_ready in a cycle -> acc_valid clears next cycle unless a dump in that same cycle, in which case acc_valid stays 1 with new data and no overrun.
- Overrun: dump while acc_valid && !acc_ready -> outputs overwritten with new epoch, acc_valid stays 1, overrun = 1 for cycle n+1 only.
- Outputs stable whenever acc_valid is 1 and no dump occurs.
- en low: accumulators, counter, internal ovf held at 0; dump ignored; output registers and acc_valid keep value and handshake still operates.
- Reset mid-epoch discards partial sums; no acc_valid generated.
- Two dumps back-to-back: second epoch has sample_cnt 0 or 1 and corresponding sums; legal.

Test Plan:
- Reset then en=1, 10 samples ch0 I=+3,Q=-2, all others 0, dump on 10th sample cycle -> next cycle acc_valid=1, ch0 I=30, Q=-20, sample_cnt=10, ovf=0.
- SAT_EN=1, ACC_W=8, ch1 I=+3 for 50 samples then dump -> ch1 I=127, ovf[1]=1, ovf[0]=0; SAT_EN=0 same stimulus -> I=150-256=-106, ovf[1]=1.
- acc_ready held 0, two dumps 20 cycles apart with different data -> overrun pulses 1 cycle after second dump, outputs show second epoch, acc_valid stays 1.
- acc_ready=1 and dump in same cycle while acc_valid=1 -> acc_valid remains 1, new data presented, overrun=0.
- Dump without sample_valid in epoch -> sample_cnt=0, all sums 0, acc_valid=1.
- nrst low mid-epoch after 5 samples, release, 3 samples I=+1, dump -> I=3, sample_cnt=3; en=0 with dump -> no acc_valid.
